pwu_req_arbiter: RTL

- Round-robin scheduler that shares the single page-walk unit between NUM_REQ translation requesters (e.g. I-side, D-side, prefetch, DMA).
- The walk unit completes translations strictly in acceptance order. The arbiter records the requester ID of every accepted VA in an in-order tag FIFO.
- Each returned PA/fault is routed back to the owning requester using that FIFO.
- Sits directly in front of the walk unit's VA input IF and behind its PA output IF.

---
 rtl/pwu_req_arbiter_pkg.sv | 17 +
 rtl/pwu_req_arbiter_if.sv | 44 ++++
 rtl/pwu_req_arbiter_tag_fifo.sv | 59 +++++
 rtl/pwu_req_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/pwu_req_arbiter_pkg.sv
// pwu_pkg: shared widths and types for the page-walk request arbiter.
// Optional feature macro used by the arbiter: PWU_ARB_FAULT_CNT_EN.
package pwu_pkg;

    localparam int VA_W = 32;
    localparam int PA_W = 28;

    typedef logic [VA_W-1:0] va_t;
    typedef logic [PA_W-1:0] pa_t;

    // One walk-unit result as seen by a requester
    typedef struct packed {
        pa_t  pa;
        logic fault;
    } rsp_t;

endpackage

// File: rtl/pwu_req_arbiter_if.sv
// pwu_req_arbiter_if: requester-side and walk-unit-side handshakes of the arbiter.
// master = arbiter view, slave = environment (requesters + walk unit) view.
interface pwu_req_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import pwu_pkg::*;

    // Requester VA channel
    va_t [NUM_REQ-1:0]  req_va_i;
    logic [NUM_REQ-1:0] req_vld_i;
    logic [NUM_REQ-1:0] req_rdy_o;

    // Requester response channel (PA/fault broadcast, one-hot valid)
    pa_t                rsp_pa_o;
    logic               rsp_fault_o;
    logic [NUM_REQ-1:0] rsp_vld_o;
    logic [NUM_REQ-1:0] rsp_rdy_i;

    // Walk unit VA input
    va_t                pwu_va_o;
    logic               pwu_va_vld_o;
    logic               pwu_va_rdy_i;

    // Walk unit PA output
    pa_t                pwu_pa_i;
    logic               pwu_pa_vld_i;
    logic               pwu_pa_fault_i;
    logic               pwu_pa_rdy_o;

    modport master (
        input  req_va_i, req_vld_i, rsp_rdy_i, pwu_va_rdy_i,
               pwu_pa_i, pwu_pa_vld_i, pwu_pa_fault_i,
        output req_rdy_o, rsp_pa_o, rsp_fault_o, rsp_vld_o,
               pwu_va_o, pwu_va_vld_o, pwu_pa_rdy_o
    );

    modport slave (
        output req_va_i, req_vld_i, rsp_rdy_i, pwu_va_rdy_i,
               pwu_pa_i, pwu_pa_vld_i, pwu_pa_fault_i,
        input  req_rdy_o, rsp_pa_o, rsp_fault_o, rsp_vld_o,
               pwu_va_o, pwu_va_vld_o, pwu_pa_rdy_o
    );

endinterface

// File: rtl/pwu_req_arbiter_tag_fifo.sv
// pwu_tag_fifo: in-order FIFO of requester IDs for translations in flight.
// Head is read combinationally so responses route with zero latency.
module pwu_tag_fifo #(
    parameter  int W     = 2,
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          resetn_i,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    // Full/empty come from the registered count only: a pop never frees a slot for a same-cycle push
    assign full_o  = (r_cnt == CW'(DEPTH));
    assign empty_o = (r_cnt == '0);
    assign count_o = r_cnt;
    assign dout_o  = r_mem[r_rd_ptr];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    // Tag storage write; contents need no reset because the count gates visibility
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din_i;
        end
    end

    // Pointers wrap naturally at DEPTH; count moves only on unbalanced push/pop
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/pwu_req_arbiter.sv
// pwu_req_arbiter: round-robin sharing of one page-walk unit among NUM_REQ
// requesters, with in-order routing of results back via a tag FIFO.
// Optional: define PWU_ARB_FAULT_CNT_EN for per-requester saturating fault counters.
module pwu_req_arbiter
    import pwu_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int OUTST_DEPTH = 8,
    localparam int IDW         = $clog2(NUM_REQ),
    localparam int CW          = $clog2(OUTST_DEPTH + 1)
) (
    input  logic                     clk_i,
    input  logic                     resetn_i,
    pwu_req_arbiter_if.master        bus,
    output logic [CW-1:0]            outst_cnt_o,
    output logic                     busy_o,
`ifdef PWU_ARB_FAULT_CNT_EN
    output logic [NUM_REQ-1:0][15:0] fault_cnt_o,
`endif
    output logic                     err_o
);

    logic [IDW-1:0]     r_rr_ptr;
    logic               r_err;
    logic [NUM_REQ-1:0] w_rot;
    logic [NUM_REQ-1:0] w_first;
    logic [NUM_REQ:0]   w_lower;
    logic [IDW-1:0]     w_off_acc [NUM_REQ+1];
    logic [IDW:0]       w_sum;
    logic [IDW-1:0]     w_grant;
    logic [IDW-1:0]     w_grant_next;
    logic               w_any;
    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_pop;
    logic [IDW-1:0]     w_head;
    rsp_t               w_rsp;

    localparam logic [IDW:0] NR = (IDW + 1)'(NUM_REQ);

    // Rotate the valids so bit 0 is the requester at rr_ptr, then pick the lowest set bit
    always_comb begin
        w_rot = NUM_REQ'({bus.req_vld_i, bus.req_vld_i} >> r_rr_ptr);
    end

    assign w_lower[0]   = 1'b0;
    assign w_off_acc[0] = '0;
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pri
            assign w_first[gi]      = w_rot[gi] & ~w_lower[gi];
            assign w_lower[gi+1]    = w_lower[gi] | w_rot[gi];
            assign w_off_acc[gi+1]  = w_off_acc[gi] | (w_first[gi] ? IDW'(gi) : '0);
        end
    endgenerate

    // Un-rotate: grant = (rr_ptr + offset) mod NUM_REQ
    assign w_any        = w_lower[NUM_REQ];
    assign w_sum        = {1'b0, r_rr_ptr} + {1'b0, w_off_acc[NUM_REQ]};
    assign w_grant      = (w_sum >= NR) ? IDW'(w_sum - NR) : w_sum[IDW-1:0];
    assign w_grant_next = (w_grant == IDW'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;

    // Request side: zero-latency pass of the granted VA, blocked while the tag FIFO is full
    assign bus.pwu_va_vld_o = w_any && !w_full;
    assign bus.pwu_va_o     = w_any ? bus.req_va_i[w_grant] : '0;
    assign bus.req_rdy_o    = (w_any && !w_full && bus.pwu_va_rdy_i) ?
                              (NUM_REQ'(1) << w_grant) : '0;
    assign w_accept         = bus.pwu_va_vld_o && bus.pwu_va_rdy_i;

    // Response side: route to the oldest outstanding owner; drain anything arriving with nothing outstanding
    assign w_rsp.pa         = bus.pwu_pa_i;
    assign w_rsp.fault      = bus.pwu_pa_fault_i;
    assign bus.rsp_pa_o     = w_rsp.pa;
    assign bus.rsp_fault_o  = w_rsp.fault;
    assign bus.rsp_vld_o    = (!w_empty && bus.pwu_pa_vld_i) ? (NUM_REQ'(1) << w_head) : '0;
    assign bus.pwu_pa_rdy_o = w_empty ? 1'b1 : bus.rsp_rdy_i[w_head];
    assign w_pop            = !w_empty && bus.pwu_pa_vld_i && bus.pwu_pa_rdy_o;

    pwu_tag_fifo #(
        .W     (IDW),
        .DEPTH (OUTST_DEPTH)
    ) u_tag_fifo (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .push_i   (w_accept),
        .din_i    (w_grant),
        .pop_i    (w_pop),
        .dout_o   (w_head),
        .full_o   (w_full),
        .empty_o  (w_empty),
        .count_o  (outst_cnt_o)
    );

    assign busy_o = (outst_cnt_o != '0);
    assign err_o  = r_err;

    // Round-robin pointer moves past the winner only when its VA is actually accepted
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= w_grant_next;
        end
    end

    // Sticky error: a walk result arrived with no translation outstanding
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_err <= 1'b0;
        end else if (w_empty && bus.pwu_pa_vld_i) begin
            r_err <= 1'b1;
        end
    end

`ifdef PWU_ARB_FAULT_CNT_EN
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fcnt
            logic [15:0] r_fcnt;
            // Count faulted responses delivered to this requester, saturating at all-ones
            always_ff @(posedge clk_i or negedge resetn_i) begin
                if (!resetn_i) begin
                    r_fcnt <= '0;
                end else if (w_pop && bus.pwu_pa_fault_i && (w_head == IDW'(gi)) &&
                             (r_fcnt != 16'hFFFF)) begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end
            assign fault_cnt_o[gi] = r_fcnt;
        end
    endgenerate
`endif

endmodule
